onchip_memory_pipelined: RTL and testbench

Parametrised single-port Avalon-MM on-chip RAM slave, the successor to the fixed 32x32K SoC memory. It is generalised in width, depth and read latency, and adds readdatavalid, waitrequest flow control and an optional post-reset zero-clear sequencer. It is instantiated by Qsys-style system top levels (stepmotor and later projects) as program/data memory behind the interconnect.

---
 rtl/onchip_memory_pipelined.sv | 130 +++++++++++++
 tb/tb_onchip_memory_pipelined.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_pipelined.sv
// Single-port Avalon-MM on-chip RAM slave with a configurable read pipeline,
// waitrequest flow control and an optional post-reset zero-clear sequencer.
module onchip_memory_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 15,
    parameter int DEPTH          = 32768,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b0,
    parameter     INIT_FILE      = "onchip_memory_pipelined.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    reset_req,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done
);

    // state    | meaning
    // ST_BOOT  | first cycle after reset, no clear requested
    // ST_CLEAR | writing zero to word[clr_cnt_q], one word per unstalled cycle
    // ST_READY | accesses accepted whenever not stalled

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t state_q, state_d;

    logic                  stall;
    logic                  accept;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      clr_cnt_q;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    // Preloading from INIT_FILE is left to the device memory-init flow; the
    // array itself is never reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign stall       = ~clken | reset_req;
    assign waitrequest = (state_q != ST_READY) | stall;
    assign init_done   = (state_q == ST_READY);

    assign accept   = chipselect & ~waitrequest;
    assign wr_acc   = accept & write;
    assign rd_acc   = accept & read & ~write;
    assign in_range = {1'b0, address} < DEPTH_C;
    assign idx      = address[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
            else                state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                ST_BOOT:  state_d = ST_READY;
                ST_CLEAR: if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
                ST_READY: state_d = ST_READY;
                default:  state_d = ST_READY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q <= '0;
        end else if (!stall && state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    // Data registers only load behind a valid bit, so readdata keeps the last
    // returned word between returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else if (!stall) begin
            vld_q[0] <= rd_acc;
            if (rd_acc) dat_q[0] <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Randomised self-checking bench for onchip_memory_pipelined against a
// queue-based reference model (clear on reset, DEPTH=10, latency 3).
module tb_onchip_memory_pipelined;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 10;
    localparam int RL    = 3;
    localparam bit CLR   = 1'b1;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          clken;
    logic          reset_req;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic          init_done;

    onchip_memory_pipelined #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DEPTH         (DEPTH),
        .READ_LATENCY  (RL),
        .CLEAR_ON_RESET(CLR),
        .INIT_FILE     ("")
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .byteenable   (byteenable),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .clken        (clken),
        .reset_req    (reset_req),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .waitrequest  (waitrequest),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            left;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            boot_left;
    logic          exp_valid;
    logic [DW-1:0] exp_rdata;
    int            n_tests;
    int            n_fail;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One bus cycle: drive, check the combinational handshake, advance the
    // model across the edge, then check the registered read outputs.
    task automatic tick(input logic cs, input logic rd, input logic wr,
                        input logic [AW-1:0] addr, input logic [3:0] be,
                        input logic [DW-1:0] wd, input logic ce, input logic rr);
        logic stall;
        logic ready;
        logic [DW-1:0] v;
        chipselect = cs; read = rd; write = wr; address = addr;
        byteenable = be; writedata = wd; clken = ce; reset_req = rr;
        #1;
        stall = !ce || rr;
        ready = (boot_left == 0);
        chk("waitrequest", {31'd0, waitrequest}, {31'd0, !ready || stall});
        chk("init_done", {31'd0, init_done}, {31'd0, ready});
        if (!stall) begin
            if (ready && cs) begin
                if (wr) begin
                    if (addr < DEPTH)
                        for (int b = 0; b < 4; b++)
                            if (be[b]) mem_m[addr][8*b +: 8] = wd[8*b +: 8];
                end else if (rd) begin
                    v = (addr < DEPTH) ? mem_m[addr] : '0;
                    pend.push_back('{data: v, left: RL});
                end
            end
            if (boot_left > 0) begin
                boot_left--;
                if (boot_left == 0 && CLR)
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end
            foreach (pend[i]) pend[i].left = pend[i].left - 1;
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].left == 0) begin
                exp_valid = 1'b1;
                exp_rdata = pend[0].data;
                void'(pend.pop_front());
            end
        end
        @(posedge clk);
        #1;
        chk("readdatavalid", {31'd0, readdatavalid}, {31'd0, exp_valid});
        chk("readdata", readdata, exp_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0, '0, 1, 0);
    endtask

    task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        tick(1, 0, 1, a, be, d, 1, 0);
    endtask

    task automatic rd_word(input logic [AW-1:0] a);
        tick(1, 1, 0, a, '0, '0, 1, 0);
    endtask

    task automatic do_reset();
        chipselect = 0; read = 0; write = 0; address = '0;
        byteenable = '0; writedata = '0; clken = 1; reset_req = 0;
        reset_n = 1'b0;
        pend.delete();
        exp_valid = 1'b0;
        exp_rdata = '0;
        boot_left = CLR ? DEPTH : 1;
        @(posedge clk);
        #1;
        chk("rst_readdatavalid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b1;
        chipselect = 0; read = 0; write = 0; address = '0;
        byteenable = '0; writedata = '0; clken = 1; reset_req = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        #2;
        do_reset();

        // Abort the clear part-way, then run a full clear with two stall cycles.
        idle(7);
        do_reset();
        for (int i = 0; i < DEPTH + 4; i++) tick(0, 0, 0, '0, '0, '0, !(i == 4 || i == 5), 0);

        for (int i = 0; i < DEPTH; i++) rd_word(AW'(i));
        idle(RL + 1);

        wr_word(5, 32'hAABBCCDD, 4'hF);
        wr_word(5, 32'h11223344, 4'b0101);
        rd_word(5);
        idle(RL + 1);
        chk("byte_lanes", readdata, 32'hAA22CC44);

        for (int i = 0; i < 4; i++) wr_word(AW'(i), 32'h10 + i, 4'hF);
        for (int i = 0; i < 4; i++) rd_word(AW'(i));
        idle(RL + 1);
        chk("b2b_last", readdata, 32'h13);

        // Two reads in flight, then two stalled cycles offering a third read.
        rd_word(1);
        rd_word(2);
        tick(1, 1, 0, 3, '0, '0, 0, 0);
        tick(1, 1, 0, 3, '0, '0, 0, 0);
        idle(RL + 2);
        chk("stall_data", readdata, 32'h12);

        wr_word(9, 32'h99999999, 4'hF);
        wr_word(10, 32'hFFFFFFFF, 4'hF);
        wr_word(31, 32'hFFFFFFFF, 4'hF);
        rd_word(10);
        idle(RL + 1);
        chk("oor_read", readdata, 32'h0);
        rd_word(9);
        idle(RL + 1);
        chk("word9_kept", readdata, 32'h99999999);

        tick(1, 1, 1, 2, 4'hF, 32'h5A5A5A5A, 1, 0);
        idle(RL + 1);
        rd_word(2);
        idle(RL + 1);
        chk("rw_write_done", readdata, 32'h5A5A5A5A);

        wr_word(4, 32'hDEADBEEF, 4'h0);
        rd_word(4);
        idle(RL + 1);

        for (int i = 0; i < 2000; i++) begin
            int op;
            logic [AW-1:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 15) == 0) ? AW'(31) : AW'($urandom_range(0, 15));
            tick($urandom_range(0, 3) != 0, (op < 5) || (op == 9), op >= 5, a,
                 4'($urandom_range(0, 15)), DW'($urandom),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
        end
        idle(RL + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
